// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog controller: FSM states,
// register map and STATUS word layout.
package wdt_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RUN      = 3'd2,
        ST_KICK     = 3'd3,
        ST_EXPIRED  = 3'd4
    } wdt_state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_CNT    = 2'd1;
    localparam logic [1:0] ADDR_KICK   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_IRQ_BIT   = 3;
    localparam int STAT_RST_BIT   = 4;
    localparam int STAT_ERR_BIT   = 5;

    function automatic logic [31:0] status_word(input logic [2:0] st,
                                                input logic       irq,
                                                input logic       rst_req,
                                                input logic       err);
        logic [31:0] w;
        w = '0;
        w[STAT_STATE_LSB +: 3] = st;
        w[STAT_IRQ_BIT]        = irq;
        w[STAT_RST_BIT]        = rst_req;
        w[STAT_ERR_BIT]        = err;
        return w;
    endfunction

endpackage

// File: rtl/wdt_stretch.sv
// Pulse stretcher shared by the LOAD and KICK phases: a start pulse raises
// the selected output for STRETCH cycles, done marks its final cycle.
module wdt_stretch
    import wdt_pkg::*;
#(
    parameter int unsigned STRETCH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic sel,
    output logic out_a,
    output logic out_b,
    output logic done
);

    localparam logic [31:0] RELOAD = 32'(STRETCH - 1);

    logic [31:0] cnt_q, cnt_d;
    logic        out_a_q, out_a_d;
    logic        out_b_q, out_b_d;
    logic        busy;

    assign busy = out_a_q | out_b_q;
    assign done = busy && (cnt_q == '0);

    always_comb begin
        cnt_d   = cnt_q;
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        if (start) begin
            cnt_d   = RELOAD;
            out_a_d = ~sel;
            out_b_d = sel;
        end else if (done) begin
            out_a_d = 1'b0;
            out_b_d = 1'b0;
        end else if (busy) begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            out_a_q <= 1'b0;
            out_b_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
        end
    end

    assign out_a = out_a_q;
    assign out_b = out_b_q;

endmodule

// File: rtl/wdt_ctrl.sv
// System-clock watchdog controller: CPU registers, WDEN/WDLIVE sequencing,
// timeout interrupt and grace-window reset request.
//
// state       | meaning
// DISABLED    | watchdog off, CNT writable
// LOAD        | WDEN stretched so the WDT reloads from WTOCNT
// RUN         | counting, waiting for kick / timeout / disable
// KICK        | WDLIVE stretched, inputs ignored
// EXPIRED     | irq raised, grace window running toward sys_rst_req
module wdt_ctrl
    import wdt_pkg::*;
#(
    parameter int unsigned STRETCH  = 4,
    parameter logic [31:0] GRACE    = 32'd1024,
    parameter logic [31:0] KICK_KEY = 32'h5A5A_A5A5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_we,
    input  logic        reg_re,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    input  logic        wto_sync,
    output logic        WDEN,
    output logic        WDLIVE,
    output logic [31:0] WTOCNT,
    output logic        wdt_irq,
    output logic        sys_rst_req
);

    wdt_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] grace_q, grace_d;
    logic [31:0] wtocnt_q, wtocnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        irq_q, irq_d;
    logic        rst_req_q, rst_req_d;
    logic        start_q, start_d;
    logic        sel_q, sel_d;
    logic        err_set;
    logic        stretch_done;

    logic wr_ctrl, wr_cnt, wr_kick, key_ok, rd_status;

    assign wr_ctrl   = reg_we && (reg_addr == ADDR_CTRL);
    assign wr_cnt    = reg_we && (reg_addr == ADDR_CNT);
    assign wr_kick   = reg_we && (reg_addr == ADDR_KICK);
    assign key_ok    = (reg_wdata == KICK_KEY);
    assign rd_status = reg_re && (reg_addr == ADDR_STATUS);

    wdt_stretch #(.STRETCH(STRETCH)) u_stretch (
        .clk   (clk),
        .rst   (rst),
        .start (start_q),
        .sel   (sel_q),
        .out_a (WDEN),
        .out_b (WDLIVE),
        .done  (stretch_done)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        unique case (state_q)
            ST_DISABLED: begin
                if (wr_ctrl && reg_wdata[0]) begin
                    if (cnt_q != '0) state_d = ST_LOAD;
                    else             err_set = 1'b1;
                end else if (wr_cnt) begin
                    cnt_d = reg_wdata;
                end
            end
            ST_LOAD: if (stretch_done) state_d = ST_RUN;
            ST_RUN: begin
                if (wto_sync)                       state_d = ST_EXPIRED;
                else if (wr_kick)                   state_d = key_ok ? ST_KICK : ST_EXPIRED;
                else if (wr_ctrl && !reg_wdata[0])  state_d = ST_DISABLED;
            end
            ST_KICK: if (stretch_done) state_d = ST_RUN;
            ST_EXPIRED: if (!rst_req_q && wr_kick && key_ok) state_d = ST_LOAD;
            default: state_d = ST_DISABLED;
        endcase

        if (wr_cnt && state_q != ST_DISABLED) err_set = 1'b1;

        // Stretcher is launched from a flop so pulses start one cycle after state entry.
        start_d = (state_d != state_q) && (state_d == ST_LOAD || state_d == ST_KICK);
        sel_d   = (state_d == ST_KICK);

        if (state_q == ST_EXPIRED && state_d == ST_EXPIRED)
            grace_d = (grace_q == GRACE) ? grace_q : grace_q + 32'd1;
        else
            grace_d = '0;

        rst_req_d = rst_req_q ||
                    (state_q == ST_EXPIRED && state_d == ST_EXPIRED && grace_d == GRACE);
        irq_d     = (state_d == ST_EXPIRED);
        err_d     = err_set || (err_q && !rd_status);
        wtocnt_d  = cnt_q;

        rdata_d = rdata_q;
        if (reg_re) begin
            unique case (reg_addr)
                ADDR_CTRL:   rdata_d = {31'd0, state_q != ST_DISABLED};
                ADDR_CNT:    rdata_d = cnt_q;
                ADDR_KICK:   rdata_d = '0;
                ADDR_STATUS: rdata_d = status_word(state_q, irq_q, rst_req_q, err_q);
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_DISABLED;
            cnt_q     <= '0;
            grace_q   <= '0;
            wtocnt_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
            rst_req_q <= 1'b0;
            start_q   <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grace_q   <= grace_d;
            wtocnt_q  <= wtocnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
            rst_req_q <= rst_req_d;
            start_q   <= start_d;
            sel_q     <= sel_d;
        end
    end

    assign reg_rdata   = rdata_q;
    assign WTOCNT      = wtocnt_q;
    assign wdt_irq     = irq_q;
    assign sys_rst_req = rst_req_q;

endmodule
